// File: rtl/mrf_pkg.sv
// ---------------------------------------------------------------------------
// mrf_pkg
// Shared definitions for the sliding-window row writer:
//   - default values of the block parameters (WORDWIDTH, IN_NUM, OUT_NUM,
//     CHANNEL), used as the module parameter defaults;
//   - mrf_npos / mrf_cw: number of window positions and width of the window
//     index, computed from the actual module parameters;
//   - NPOS / CW: the same quantities at the default parameter values;
//   - mrf_state_e: output-side FSM states.
// ---------------------------------------------------------------------------
package mrf_pkg;

    localparam int DEF_WORDWIDTH = 32;
    localparam int DEF_IN_NUM    = 14;
    localparam int DEF_OUT_NUM   = 5;
    localparam int DEF_CHANNEL   = 6;

    // Number of distinct window positions across one row.
    function automatic int mrf_npos(input int in_num, input int out_num);
        return in_num - out_num + 1;
    endfunction

    // Width of the window index that spans 0 .. NPOS-1.
    function automatic int mrf_cw(input int in_num, input int out_num);
        return $clog2(in_num + 1 - out_num);
    endfunction

    localparam int NPOS = mrf_npos(DEF_IN_NUM, DEF_OUT_NUM);
    localparam int CW   = mrf_cw(DEF_IN_NUM, DEF_OUT_NUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SWEEP = 2'd2
    } mrf_state_e;

endpackage

// File: rtl/mrf_row_fill.sv
// ---------------------------------------------------------------------------
// mrf_row_fill
// Fill side of the double-buffered row writer. Collects IN_NUM beats of
// CHANNEL words into a row buffer; slot k holds the k-th accepted beat.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_valid_i     input beat valid
//   s_ready_o     beat accepted when s_valid_i & s_ready_o
//   s_data_i      one beat, channel c at [c*WORDWIDTH +: WORDWIDTH]
//   s_last_i      short-row marker (used only with MRF_ROW_PAD_EN)
//   load_i        row taken by the output side; clears the fill index
//   fill_full_o   buffer holds a complete row
//   row_o         packed buffer contents, slot k at [k*CHANNEL*WORDWIDTH +: ...]
//
// Build option MRF_ROW_PAD_EN: an accepted beat with s_last_i=1 completes the
// row immediately, zero-filling all higher slots on the same edge.
// ---------------------------------------------------------------------------
module mrf_row_fill
    import mrf_pkg::*;
#(
    parameter int WORDWIDTH = DEF_WORDWIDTH,
    parameter int IN_NUM    = DEF_IN_NUM,
    parameter int CHANNEL   = DEF_CHANNEL
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid_i,
    output logic                                s_ready_o,
    input  logic [CHANNEL*WORDWIDTH-1:0]        s_data_i,
    input  logic                                s_last_i,
    input  logic                                load_i,
    output logic                                fill_full_o,
    output logic [CHANNEL*IN_NUM*WORDWIDTH-1:0] row_o
);

    localparam int SW = CHANNEL * WORDWIDTH;
    localparam int IW = $clog2(IN_NUM + 1);
    localparam logic [IW-1:0] FULL_IDX = IW'(IN_NUM);

    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [SW-1:0] slot_q [IN_NUM];
    logic          accept;
    logic          pad;

    assign fill_full_o = (fill_idx_q == FULL_IDX);
    // No bypass: a buffer freed by load_i accepts beats from the next cycle.
    assign s_ready_o   = ~rst & ~fill_full_o;
    assign accept      = s_valid_i & s_ready_o;

`ifdef MRF_ROW_PAD_EN
    assign pad = accept & s_last_i;
`else
    logic unused_s_last;
    assign pad           = 1'b0;
    assign unused_s_last = s_last_i;
`endif

    always_comb begin
        fill_idx_d = fill_idx_q;
        if (load_i) begin
            fill_idx_d = '0;
        end else if (pad) begin
            fill_idx_d = FULL_IDX;
        end else if (accept) begin
            fill_idx_d = fill_idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_idx_q <= '0;
        end else begin
            fill_idx_q <= fill_idx_d;
        end
    end

    // Slot contents need no reset: every slot of a row is written (or
    // zero-padded) before fill_full_o can rise.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_NUM; k++) begin
            if (accept) begin
                if (fill_idx_q == IW'(k)) begin
                    slot_q[k] <= s_data_i;
                end else if (pad && (IW'(k) > fill_idx_q)) begin
                    slot_q[k] <= '0;
                end
            end
        end
    end

    for (genvar k = 0; k < IN_NUM; k++) begin : g_row
        assign row_o[k*SW +: SW] = slot_q[k];
    end

endmodule

// File: rtl/mrf_row_writer.sv
// ---------------------------------------------------------------------------
// mrf_row_writer
// Producer side of the sliding-window row register file. Packs IN_NUM input
// beats into a row, hands the row to the window register file and sweeps the
// window index from 0 to IN_NUM-OUT_NUM. The next row fills while the
// current one is swept.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   s_valid     input beat valid
//   s_ready     input beat accepted when s_valid & s_ready
//   s_data      one beat, channel c at [c*WORDWIDTH +: WORDWIDTH]
//   s_last      short-row marker (used only with MRF_ROW_PAD_EN)
//   row_data    packed row, slot k at [k*CHANNEL*WORDWIDTH +: CHANNEL*WORDWIDTH]
//   row_load    one-cycle pulse in the first cycle a new row_data is visible
//   count       window position, 0 .. NPOS-1
//   win_valid   count is valid for the consumer
//   win_ready   consumer accepted the current count
//
// Build option MRF_ROW_PAD_EN (handled in mrf_row_fill): s_last ends a short
// row, remaining slots are zero-filled.
// ---------------------------------------------------------------------------
module mrf_row_writer
    import mrf_pkg::*;
#(
    parameter int WORDWIDTH = DEF_WORDWIDTH,
    parameter int IN_NUM    = DEF_IN_NUM,
    parameter int OUT_NUM   = DEF_OUT_NUM,
    parameter int CHANNEL   = DEF_CHANNEL
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [CHANNEL*WORDWIDTH-1:0]           s_data,
    input  logic                                   s_last,
    output logic [CHANNEL*IN_NUM*WORDWIDTH-1:0]    row_data,
    output logic                                   row_load,
    output logic [$clog2(IN_NUM+1-OUT_NUM)-1:0]    count,
    output logic                                   win_valid,
    input  logic                                   win_ready
);

    localparam int NUM_POS = mrf_npos(IN_NUM, OUT_NUM);
    localparam int CNT_W   = mrf_cw(IN_NUM, OUT_NUM);
    localparam int RW      = CHANNEL * IN_NUM * WORDWIDTH;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(NUM_POS - 1);

    mrf_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RW-1:0]     row_q, row_d;
    logic              fill_full;
    logic [RW-1:0]     fill_row;
    logic              last_acc;
    logic              load;

    mrf_row_fill #(
        .WORDWIDTH (WORDWIDTH),
        .IN_NUM    (IN_NUM),
        .CHANNEL   (CHANNEL)
    ) u_fill (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .load_i      (load),
        .fill_full_o (fill_full),
        .row_o       (fill_row)
    );

    // The output side is free when idle, or when the final window position
    // is being accepted; a full fill buffer is then copied into row_data.
    assign last_acc = (state_q == SWEEP) && win_ready && (count_q == LAST_POS);
    assign load     = fill_full && ((state_q == IDLE) || last_acc);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        row_d   = row_q;
        if (load) begin
            row_d = fill_row;
        end
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = PRIME;
                end
            end
            // One dead cycle so the consumer can register the new row.
            PRIME: begin
                state_d = SWEEP;
            end
            SWEEP: begin
                if (win_ready) begin
                    if (count_q == LAST_POS) begin
                        count_d = '0;
                        state_d = load ? PRIME : IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        row_load  = 1'b0;
        win_valid = 1'b0;
        unique case (state_q)
            PRIME:   row_load  = 1'b1;
            SWEEP:   win_valid = 1'b1;
            default: ;
        endcase
    end

    assign count    = count_q;
    assign row_data = row_q;

endmodule

// File: tb/tb_mrf_row_writer.sv
module tb_mrf_row_writer;

    localparam int WORDWIDTH = 32;
    localparam int IN_NUM    = 14;
    localparam int OUT_NUM   = 5;
    localparam int CHANNEL   = 6;
    localparam int NPOS      = IN_NUM - OUT_NUM + 1;
    localparam int CW        = $clog2(NPOS);
    localparam int SW        = CHANNEL * WORDWIDTH;
    localparam int RW        = CHANNEL * IN_NUM * WORDWIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_data;
    logic          s_last;
    logic [RW-1:0] row_data;
    logic          row_load;
    logic [CW-1:0] count;
    logic          win_valid;
    logic          win_ready;

    mrf_row_writer #(
        .WORDWIDTH (WORDWIDTH),
        .IN_NUM    (IN_NUM),
        .OUT_NUM   (OUT_NUM),
        .CHANNEL   (CHANNEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .row_data  (row_data),
        .row_load  (row_load),
        .count     (count),
        .win_valid (win_valid),
        .win_ready (win_ready)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_mode;               // 0: ready high, 1: random, 3: driven directly

    // Reference model state
    logic [RW-1:0] rowq [$];   // completed rows not yet presented
    logic [RW-1:0] part_row;   // row being assembled from accepted beats
    int            part_n;
    logic [RW-1:0] cur_row;    // row the consumer should currently see
    bit            exp_load;   // a row is expected to load at the coming edge
    bit            sweeping;   // a row is presented and not fully consumed
    int            pos;        // next window position to be offered

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < IN_NUM * CHANNEL; i++) begin
                if (act[i*WORDWIDTH +: WORDWIDTH] !== exp[i*WORDWIDTH +: WORDWIDTH]) begin
                    $display("FAIL %s: slot %0d ch %0d got 0x%0h expected 0x%0h (t=%0t)", nm,
                             i / CHANNEL, i % CHANNEL, act[i*WORDWIDTH +: WORDWIDTH],
                             exp[i*WORDWIDTH +: WORDWIDTH], $time);
                    break;
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs every cycle against the model, then
    // advances the model by what will happen at the next rising edge.
    task automatic mon_step();
        bit exp_valid;
        bit last_acc;
        bit done;
        if (rst) begin
            chk("s_ready_in_rst", 64'(s_ready), 64'(0));
            rowq.delete();
            part_row = '0;
            part_n   = 0;
            cur_row  = '0;
            exp_load = 0;
            sweeping = 0;
            pos      = 0;
            return;
        end
        chk("row_load", 64'(row_load), 64'(exp_load));
        if (exp_load) begin
            cur_row  = rowq.pop_front();
            pos      = 0;
            sweeping = 1;
        end
        exp_valid = sweeping && !exp_load;
        chk("win_valid", 64'(win_valid), 64'(exp_valid));
        chk("count", 64'(count), exp_valid ? 64'(pos) : 64'(0));
        chk_row("row_data", row_data, cur_row);
        chk("s_ready", 64'(s_ready), 64'(rowq.size() == 0));

        last_acc = exp_valid && win_ready && (pos == NPOS - 1);
        exp_load = (rowq.size() > 0) && (!sweeping || last_acc);
        if (exp_valid && win_ready) begin
            if (pos == NPOS - 1) begin
                pos      = 0;
                sweeping = 0;
            end else begin
                pos++;
            end
        end

        if (s_valid && s_ready) begin
            part_row[part_n*SW +: SW] = s_data;
            part_n++;
            done = (part_n == IN_NUM);
`ifdef MRF_ROW_PAD_EN
            if (s_last) done = 1;
`endif
            if (done) begin
                rowq.push_back(part_row);
                part_row = '0;
                part_n   = 0;
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [SW-1:0] d, input bit last);
        bit ok;
        ok      = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        sync();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("send_accept", 64'(ok), 64'(1));
    endtask

    function automatic logic [SW-1:0] beat_pat(input int k);
        logic [SW-1:0] d;
        for (int c = 0; c < CHANNEL; c++) d[c*WORDWIDTH +: WORDWIDTH] = WORDWIDTH'(k * 16 + c);
        return d;
    endfunction

    function automatic logic [SW-1:0] beat_rand();
        logic [SW-1:0] d;
        for (int c = 0; c < CHANNEL; c++) d[c*WORDWIDTH +: WORDWIDTH] = $urandom;
        return d;
    endfunction

    task automatic drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (rowq.size() == 0 && !sweeping && !exp_load) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 64'(ok), 64'(1));
        sync();
    endtask

    initial begin
        bit            found;
        logic [RW-1:0] rd;

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = '0;
        win_ready = 1'b0;
        wr_mode   = 3;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #1;
                case (wr_mode)
                    0:       win_ready = 1'b1;
                    1:       win_ready = 1'($urandom_range(0, 1));
                    default: ;
                endcase
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_win_valid", 64'(win_valid), 64'(0));
        chk("rst_row_load", 64'(row_load), 64'(0));
        chk_row("rst_row_data", row_data, '0);
        sync();

        // One patterned row, consumer always ready
        win_ready = 1'b1;
        for (int k = 0; k < IN_NUM; k++) send(beat_pat(k), 1'b0);
        found = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (row_load) begin
                found = 1;
                break;
            end
        end
        chk("first_load_seen", 64'(found), 64'(1));
        rd = row_data;
        chk("slot13_ch5", 64'(rd[(13*CHANNEL+5)*WORDWIDTH +: WORDWIDTH]), 64'h0D5);
        for (int i = 0; i < NPOS; i++) begin
            @(negedge clk);
            chk("sweep_valid", 64'(win_valid), 64'(1));
            chk("sweep_count", 64'(count), 64'(i));
        end
        @(negedge clk);
        chk("idle_after_sweep", 64'(win_valid), 64'(0));
        sync();

        // Two rows back to back
        for (int k = 0; k < 2 * IN_NUM; k++) send(beat_rand(), 1'b0);
        drain();

        // Consumer stall at count 3
        for (int k = 0; k < IN_NUM; k++) send(beat_rand(), 1'b0);
        found = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (win_valid && count == CW'(2)) begin
                found = 1;
                break;
            end
        end
        chk("reach_count2", 64'(found), 64'(1));
        sync();
        win_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_count", 64'(count), 64'(3));
            chk("stall_valid", 64'(win_valid), 64'(1));
        end
        sync();
        win_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("resume_count", 64'(count), 64'(4));
        sync();
        drain();

        // Three rows against a stalled consumer
        win_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 3 * IN_NUM; k++) send(beat_rand(), 1'b0);
            end
            begin
                repeat (60) @(posedge clk);
                #1 win_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a sweep with a partial row buffered
        win_ready = 1'b0;
        for (int k = 0; k < IN_NUM; k++) send(beat_rand(), 1'b0);
        for (int k = 0; k < 7; k++) send(beat_rand(), 1'b0);
        win_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 40; t++) begin
            sync();
            if (win_valid && count == CW'(5)) begin
                found = 1;
                break;
            end
        end
        chk("reach_count5", 64'(found), 64'(1));
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_valid", 64'(win_valid), 64'(0));
        chk("mid_rst_load", 64'(row_load), 64'(0));
        chk_row("mid_rst_row", row_data, '0);
        chk("mid_rst_ready", 64'(s_ready), 64'(1));
        sync();
        for (int k = 0; k < IN_NUM - 1; k++) send(beat_rand(), 1'b0);
        found = 0;
        repeat (6) begin
            @(negedge clk);
            if (row_load) found = 1;
        end
        chk("no_load_13_beats", 64'(found), 64'(0));
        sync();
        send(beat_rand(), 1'b0);
        drain();

        // Short row: s_last on beat 9
        win_ready = 1'b1;
        for (int k = 0; k < 10; k++) send(beat_pat(k), k == 9);
        found = 0;
        repeat (20) begin
            @(negedge clk);
            if (row_load) found = 1;
        end
`ifdef MRF_ROW_PAD_EN
        chk("pad_row_loaded", 64'(found), 64'(1));
`else
        chk("short_row_waits", 64'(found), 64'(0));
`endif
        sync();
        for (int k = 10; k < IN_NUM; k++) send(beat_pat(k), 1'b0);
        drain();

        // Randomized traffic
        wr_mode = 1;
        for (int i = 0; i < 12 * IN_NUM; i++) begin
            repeat ($urandom_range(0, 2)) sync();
            send(beat_rand(), $urandom_range(0, 9) == 0);
        end
        wr_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
